// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit add/subtract built around one shared
// full adder. One operation is accepted per start handshake. The adder then runs
// LSB-first for WIDTH cycles, and the result is offered on a done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;

    logic [WIDTH-1:0] w_b_in;
    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_cout;

    // Subtraction is A + ~B + 1: invert B per bit here, the +1 comes from the carry FF.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
            assign w_b_in[gi] = b[gi] ^ sub;
        end
    endgenerate

    // The single shared full adder, fed from the LSBs of the shift registers.
    assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    assign w_accept = (r_state == ST_IDLE) && start_valid;
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start_valid) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)      w_state_next = ST_DONE;
            ST_DONE: if (done_ready)  w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per cycle while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a         <= a;
            r_b         <= w_b_in;
            r_carry     <= sub;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_carry  <= w_cout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                // Signed overflow: carry into the MSB differs from carry out of it.
                r_carry_out <= w_cout;
                r_overflow  <= r_carry ^ w_cout;
            end
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign done_valid  = (r_state == ST_DONE);
    assign busy        = (r_state == ST_RUN);
    assign result      = r_result;
    assign carry_out   = r_carry_out;
    assign overflow    = r_overflow;

endmodule
